// File: rtl/rv32i_types.sv
// Shared RV32I types used by the front end: opcodes, fetch FSM states,
// instruction-queue entries and the J-type immediate helper.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    // IDLE is the one-cycle "fetch pending" slot after reset.
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic rv32i_word j_imm(input rv32i_word i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] din_i,
    output logic [ENTRY_W-1:0] dout_o,
    output logic [AW:0]        count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_q;
    logic [AW-1:0]      rd_q;
    logic [AW:0]        cnt_q;

    always_ff @(posedge clk) begin
        if (push_i && !rst && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: drives imem, queues {pc, instr} for decode, handles redirects.
// Optional FETCH_JAL_REDIRECT_EN: follow jal targets at fetch time.
module fetch_stage
    import rv32i_types::*;
#(
    parameter int        DEPTH    = 4,
    parameter rv32i_word RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d;
    rv32i_word    tgt_q, tgt_d;

    logic               push;
    logic               pop;
    logic               full_d;
    logic [AW:0]        count;
    logic [AW:0]        occ_d;
    logic [ENTRY_W-1:0] head;
    fetch_entry_t       head_e;
    fetch_entry_t       new_e;
    rv32i_word          step;

    assign imem_address = pc_q;
    assign imem_read    = (state_q == FETCH) || (state_q == DRAIN);

    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready && !redirect;
    assign push     = (state_q == FETCH) && imem_resp && !redirect;

    assign new_e    = '{pc: pc_q, instr: imem_rdata};
    assign head_e   = fetch_entry_t'(head);
    assign id_pc    = head_e.pc;
    assign id_instr = head_e.instr;

    assign occ_d  = count + CW'(push) - CW'(pop);
    assign full_d = (occ_d == CW'(DEPTH));

`ifdef FETCH_JAL_REDIRECT_EN
    assign step = (imem_rdata[6:0] == op_jal) ? j_imm(imem_rdata) : 32'd4;
`else
    assign step = 32'd4;
`endif

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(redirect),
        .din_i  (new_e),
        .dout_o (head),
        .count_o(count)
    );

    // The outstanding read keeps its address; a pending target waits in tgt_q.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    if (imem_resp) begin
                        pc_d = redirect_pc;
                    end else begin
                        tgt_d   = redirect_pc;
                        state_d = DRAIN;
                    end
                end else if (imem_resp) begin
                    pc_d    = pc_q + step;
                    state_d = full_d ? STALL : FETCH;
                end
            end
            STALL: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!full_d) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_resp) begin
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    tgt_d = redirect_pc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the bench acts as imem and decode,
// predicting every queued {pc, instr} and comparing at pop time.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int          nchk = 0;
    int          nerr = 0;
    int          lat = 1;
    int          wcnt = 0;
    int          drop = 0;
    int          npop = 0;
    bit          jal_word = 1'b0;
    logic [31:0] exp_pc = 32'h60;
    logic [31:0] jal_next;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fetch_stage #(
        .DEPTH   (4),
        .RESET_PC(32'h00000060)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_address(imem_address),
        .imem_read   (imem_read),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (jal_word && a == 32'h60) return 32'h0080006F;
        return a ^ 32'hA5A5_0013;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic [31:0] w);
`ifdef FETCH_JAL_REDIRECT_EN
        if (w == 32'h0080006F) return pc + 32'd8;
`endif
        return pc + 32'd4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One cycle: act as decode and imem on the current outputs, then advance.
    task automatic tick();
        logic [63:0] e;
        if (!rst) begin
            chk("id_valid", 32'(id_valid), 32'(sb.size() != 0));
            if (id_valid && id_ready && !redirect && sb.size() != 0) begin
                e = sb.pop_front();
                chk("id_pc", id_pc, e[63:32]);
                chk("id_instr", id_instr, e[31:0]);
                npop++;
            end
        end
        imem_resp = 1'b0;
        if (rst) begin
            wcnt = 0;
            drop = 0;
        end else if (imem_read) begin
            wcnt++;
            if (wcnt >= lat) begin
                wcnt = 0;
                imem_resp = 1'b1;
                imem_rdata = mem(imem_address);
                if (drop > 0) begin
                    drop--;
                end else if (!redirect) begin
                    chk("addr", imem_address, exp_pc);
                    sb.push_back({exp_pc, mem(exp_pc)});
                    exp_pc = next_pc(exp_pc, mem(exp_pc));
                end
            end else if (redirect) begin
                drop = 1;
            end
        end
        if (rst) begin
            sb.delete();
            exp_pc = 32'h60;
        end else if (redirect) begin
            sb.delete();
            exp_pc = redirect_pc;
        end
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_read", 32'(imem_read), 32'd0);
        chk("rst_addr", imem_address, 32'h60);
        rst = 1'b0;
        tick();
        chk("first_read", 32'(imem_read), 32'd1);
        chk("first_addr", imem_address, 32'h60);
        npop = 0;
    endtask

    initial begin
        @(negedge clk);

        // in-order stream with single-cycle responses
        lat = 1;
        do_reset();
        id_ready = 1'b1;
        repeat (6) tick();
        chk("s1_pops", 32'(npop >= 3), 32'd1);

        // backpressure fills the queue and stops fetching
        do_reset();
        id_ready = 1'b0;
        repeat (8) tick();
        chk("s2_fill", 32'(sb.size()), 32'd4);
        chk("s2_stall", 32'(imem_read), 32'd0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("s2_rd70", 32'(imem_read), 32'd1);
        chk("s2_a70", imem_address, 32'h70);
        tick();
        tick();
        chk("s2_stall2", 32'(imem_read), 32'd0);
        chk("s2_fill2", 32'(sb.size()), 32'd4);
        id_ready = 1'b1;
        repeat (8) tick();
        chk("s2_pops", 32'(npop >= 5), 32'd1);

        // redirect while a slow read is outstanding
        lat = 3;
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (imem_read && imem_address == 32'h64) break;
            tick();
        end
        chk("s3_reach", imem_address, 32'h64);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        chk("s3_hold", imem_address, 32'h64);
        chk("s3_rd", 32'(imem_read), 32'd1);
        tick();
        chk("s3_new", imem_address, 32'h200);
        chk("s3_empty", 32'(id_valid), 32'd0);
        repeat (6) tick();
        chk("s3_pops", 32'(npop >= 2), 32'd1);

        // redirect coincident with response and pop
        lat = 1;
        do_reset();
        id_ready = 1'b1;
        repeat (3) tick();
        chk("s4_pre", 32'(id_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        chk("s4_empty", 32'(id_valid), 32'd0);
        chk("s4_addr", imem_address, 32'h300);
        repeat (4) tick();
        chk("s4_pops", 32'(npop >= 5), 32'd1);

        // jal word at the reset PC
        jal_word = 1'b1;
        do_reset();
        id_ready = 1'b1;
        tick();
`ifdef FETCH_JAL_REDIRECT_EN
        jal_next = 32'h68;
`else
        jal_next = 32'h64;
`endif
        chk("s5_next", imem_address, jal_next);
        repeat (3) tick();
        chk("s5_pops", 32'(npop >= 2), 32'd1);
        jal_word = 1'b0;

        // reset during an outstanding read
        lat = 3;
        do_reset();
        id_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("s6_read", 32'(imem_read), 32'd0);
        chk("s6_valid", 32'(id_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("s6_rd", 32'(imem_read), 32'd1);
        chk("s6_addr", imem_address, 32'h60);
        npop = 0;
        repeat (5) tick();
        chk("s6_pops", 32'(npop >= 1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
